muldiv_arbiter: RTL and testbench
=================================

# muldiv_arbiter

Two-port round-robin arbiter and sequencer for the shared multiply/divide unit. It accepts HI/LO operations from two requesters, such as the CPU pipeline and a coprocessor/accelerator port. It drives the unit's op/A/B inputs with the correct cycle sequencing, keeps a private HI/LO context per port, and returns the resulting {hi, lo} to the issuing port. It sits between the requesters and the multiply/divide unit and is the only driver of that unit.

## Interface
- No parameters; 2 ports, 32-bit data.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port accept; at most one bit high.
- req_op0, req_op1  in  4  requested op, using the unit's encoding.
- req_a0, req_a1, req_b0, req_b1  in  32  operands.
- rsp_valid  out  2  per-port response valid; at most one bit high.
- rsp_ready  in  2  per-port response accept.
- rsp_hi, rsp_lo  out  32  shared response data, qualified by rsp_valid.
- md_op  out  4  op to the unit; 4'b0000 = no-op.
- md_a, md_b  out  32  operands to the unit.
- md_hi, md_lo  in  32  unit HI/LO.
- md_busy  in  1  unit divide-busy.

## Operation
- **Op classes** (decoded from req_op[3:1]):
  - READ: 000 or 001. Never forwarded to the unit.
  - MTLO: 010. MTHI: 011.
  - MULT: 100. DIV: 101. MADD: 110. MSUB: 111.
  - op[0] selects unsigned and is passed through unchanged.
- **Per-port state:**
  - shadow_hi[i] and shadow_lo[i]: the port's architectural HI/LO.
  - ctx: the port whose context is currently loaded in the unit.
- **Arbitration:**
  - Acceptance happens only in IDLE.
  - If one port is valid, grant it. If both are valid, grant the port not granted last; last_grant starts at 1, so port 0 wins first.
  - req_ready[i] is asserted combinationally in the accept cycle. op, a and b are latched into owner, op_r, a_r and b_r.
- **States and transitions:**
  - IDLE:
    - READ → RESP, loading rsp from shadow[owner].
    - Restore is needed when owner≠ctx and the op is MTLO, MTHI, MADD or MSUB. In that case → R_LO.
    - Otherwise → ISSUE.
  - R_LO: md_op=0100, md_a=shadow_lo[owner] → R_HI.
  - R_HI: md_op=0110, md_a=shadow_hi[owner] → ISSUE.
  - ISSUE: md_op=op_r, md_a=a_r, md_b=b_r; ctx<=owner.
    - MADD/MSUB → ACC.
    - DIV → WDIV.
    - Otherwise → DONE.
  - ACC: md_op=0000, which lets the unit apply the accumulate → DONE.
  - WDIV: md_op=0000; md_a=a_r and md_b=b_r are held.
    - Stay while md_busy=1.
    - Go to DONE the cycle after md_busy=0 is first seen in WDIV, so the unit has written HI/LO on that edge.
  - DONE: shadow[owner] and rsp_hi/rsp_lo <= {md_hi, md_lo} → RESP.
  - RESP: rsp_valid[owner]=1. Stay until rsp_ready[owner]; on the handshake → IDLE.
- **md_op rule:** md_op is 0000 in every state except R_LO, R_HI and ISSUE.
- **md_a/md_b rule:** md_a and md_b hold their last values when not otherwise specified.
- **DIV signs:** signed/unsigned quotient and remainder sign handling is the unit's responsibility.

## Timing
- **Reset values:**
  - state=IDLE, ctx=0, last_grant=1.
  - All shadows=0; this matches the unit's own reset of HI/LO=0.
  - req_ready=0, rsp_valid=0, rsp_hi=rsp_lo=0.
  - md_op=0000, md_a=md_b=0.
- **Latency** is counted from the accept cycle (cycle 0) to the first rsp_valid cycle:
  - READ: 1.
  - MULT, and MTLO/MTHI without restore: 3.
  - MADD/MSUB without restore: 4; with restore: 6.
  - DIV: 3 + the number of WDIV cycles.
- **One op in flight:** no new accept occurs until the RESP handshake completes. This gives back-to-back throughput of one op per (latency+1) cycles with rsp_ready held high.
- **rsp_hi/rsp_lo** are stable for the whole time rsp_valid is high.
- **Both requesters valid in the same cycle:** round-robin decides the winner. The losing port's req_ready stays 0, and it must hold its request.
- **rst mid-operation:** an in-progress DIV or restore is abandoned and no response is produced. All shadows return to 0.
- **Same-port ops skip restore:** MADD on the port that is already ctx skips R_LO/R_HI.
- **MULT/DIV never restore,** because they overwrite both HI and LO.

## Test plan
- Reset, then port 0 MULT (op 1000) with a=-3, b=5 → rsp_valid[0] at cycle 3 with hi=FFFFFFFF, lo=FFFFFFF1; md_op=1000 only at cycle 1.
- Port 0 MTLO 7, then port 1 MULTU 2×3, then port 0 MADDU 1×1:
  - port 0 MADDU shows R_LO/R_HI restore (md_op 0100 then 0110), then rsp hi=0, lo=8;
  - port 1 receives hi=0, lo=6.
- Both ports valid with MULTU in the same cycle → port 0 served first, then port 1; a repeat of the pair alternates the order correctly.
- Port 1 DIV -7/2 → md_op=1010 for exactly one cycle, then 0000 while md_busy=1; rsp lo=FFFFFFFD, hi=FFFFFFFF.
- Assert rst during WDIV → no rsp_valid is produced. A subsequent READ on either port returns 0/0 in 1 cycle.
- rsp_ready held low for 5 cycles in RESP → rsp_valid and rsp data remain stable, and a pending request on the other port is not accepted until the handshake completes.

Source files
------------

// File: rtl/muldiv_arbiter_if.sv
// Request/response and multiply/divide unit bus for muldiv_arbiter.
// The arbiter uses the slave view. It serves the requesters and drives the unit.
// The master view is the environment: requesters plus the unit itself.
interface muldiv_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0;
    logic [3:0]  req_op1;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_busy;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        input  rsp_ready, md_hi, md_lo, md_busy,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, md_op, md_a, md_b
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        output rsp_ready, md_hi, md_lo, md_busy,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, md_op, md_a, md_b
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared multiply/divide unit.
// Each port keeps its own HI/LO shadow. When a port's accumulate or partial
// write needs the unit's HI/LO and another port's context is loaded, the
// shadow is first restored into the unit via MTLO/MTHI.
// The unit-facing outputs and rsp_valid are registered from the next state.
// They therefore change exactly when the state register does.
module muldiv_arbiter (
    input  logic            clk,
    input  logic            rst,
    muldiv_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_R_LO  = 3'd1,
        ST_R_HI  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ACC   = 3'd4,
        ST_WDIV  = 3'd5,
        ST_DONE  = 3'd6,
        ST_RESP  = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MTLO = 4'b0100;
    localparam logic [3:0] OP_MTHI = 4'b0110;

    // READ ops are answered from the shadow and never reach the unit.
    function automatic logic is_read(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    // Ops that only partially overwrite HI/LO, or that read them, need the owner's context.
    function automatic logic needs_ctx(input logic [3:0] op);
        logic r;
        case (op[3:1])
            3'b010, 3'b011, 3'b110, 3'b111: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op[3:1] == 3'b101);
    endfunction

    state_t      state_r, state_nx_s;
    logic        owner_r, ctx_r, last_grant_r;
    logic [3:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] shadow_hi_r [2];
    logic [31:0] shadow_lo_r [2];
    logic [3:0]  md_op_r;
    logic [31:0] md_a_r, md_b_r;
    logic [1:0]  rsp_valid_r;
    logic [31:0] rsp_hi_r, rsp_lo_r;

    logic        accept_s, grant_s;
    logic [1:0]  req_ready_s;
    logic [3:0]  sel_op_s;
    logic [31:0] sel_a_s, sel_b_s;
    logic        owner_nx_s;
    logic [3:0]  op_nx_s;
    logic [31:0] a_nx_s, b_nx_s;
    logic [3:0]  md_op_nx_s;
    logic [31:0] md_a_nx_s, md_b_nx_s;
    logic [1:0]  rsp_valid_nx_s;

    // Round-robin grant; a request is only taken while idle.
    always_comb begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (bus.req_valid == 2'b11) begin
                accept_s = 1'b1;
                grant_s  = ~last_grant_r;
            end else if (bus.req_valid == 2'b01) begin
                accept_s = 1'b1;
                grant_s  = 1'b0;
            end else if (bus.req_valid == 2'b10) begin
                accept_s = 1'b1;
                grant_s  = 1'b1;
            end else begin
                accept_s = 1'b0;
                grant_s  = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            grant_s  = 1'b0;
        end
        if (accept_s) begin
            req_ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Granted port's request, and the owner/operand values for the next cycle.
    always_comb begin
        sel_op_s   = grant_s ? bus.req_op1 : bus.req_op0;
        sel_a_s    = grant_s ? bus.req_a1  : bus.req_a0;
        sel_b_s    = grant_s ? bus.req_b1  : bus.req_b0;
        owner_nx_s = accept_s ? grant_s  : owner_r;
        op_nx_s    = accept_s ? sel_op_s : op_r;
        a_nx_s     = accept_s ? sel_a_s  : a_r;
        b_nx_s     = accept_s ? sel_b_s  : b_r;
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nx_s = ST_IDLE;
                end else if (is_read(sel_op_s)) begin
                    state_nx_s = ST_RESP;
                end else if ((grant_s != ctx_r) && needs_ctx(sel_op_s)) begin
                    state_nx_s = ST_R_LO;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_R_LO:  state_nx_s = ST_R_HI;
            ST_R_HI:  state_nx_s = ST_ISSUE;
            ST_ISSUE: begin
                if (is_acc(op_r)) begin
                    state_nx_s = ST_ACC;
                end else if (is_div(op_r)) begin
                    state_nx_s = ST_WDIV;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            ST_ACC:   state_nx_s = ST_DONE;
            ST_WDIV: begin
                // The unit writes HI/LO on the edge that ends the first non-busy cycle.
                if (bus.md_busy) begin
                    state_nx_s = ST_WDIV;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            ST_DONE:  state_nx_s = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready[owner_r]) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Unit drive and response-valid values for the state being entered.
    always_comb begin
        md_op_nx_s = OP_NOP;
        md_a_nx_s  = md_a_r;
        md_b_nx_s  = md_b_r;
        case (state_nx_s)
            ST_R_LO: begin
                md_op_nx_s = OP_MTLO;
                md_a_nx_s  = shadow_lo_r[owner_nx_s];
            end
            ST_R_HI: begin
                md_op_nx_s = OP_MTHI;
                md_a_nx_s  = shadow_hi_r[owner_nx_s];
            end
            ST_ISSUE: begin
                md_op_nx_s = op_nx_s;
                md_a_nx_s  = a_nx_s;
                md_b_nx_s  = b_nx_s;
            end
            default: begin
                md_op_nx_s = OP_NOP;
            end
        endcase
        if (state_nx_s == ST_RESP) begin
            rsp_valid_nx_s = owner_nx_s ? 2'b10 : 2'b01;
        end else begin
            rsp_valid_nx_s = 2'b00;
        end
    end

    // FSM state, latched request, loaded context and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            op_r         <= 4'b0000;
            a_r          <= 32'd0;
            b_r          <= 32'd0;
            ctx_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nx_s;
            owner_r <= owner_nx_s;
            op_r    <= op_nx_s;
            a_r     <= a_nx_s;
            b_r     <= b_nx_s;
            if (accept_s) begin
                last_grant_r <= grant_s;
            end
            if (state_r == ST_ISSUE) begin
                ctx_r <= owner_r;
            end
        end
    end

    // Per-port HI/LO shadows and the response data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                shadow_hi_r[i] <= 32'd0;
                shadow_lo_r[i] <= 32'd0;
            end
            rsp_hi_r <= 32'd0;
            rsp_lo_r <= 32'd0;
        end else if (state_r == ST_DONE) begin
            shadow_hi_r[owner_r] <= bus.md_hi;
            shadow_lo_r[owner_r] <= bus.md_lo;
            rsp_hi_r             <= bus.md_hi;
            rsp_lo_r             <= bus.md_lo;
        end else if (accept_s && is_read(sel_op_s)) begin
            rsp_hi_r <= shadow_hi_r[grant_s];
            rsp_lo_r <= shadow_lo_r[grant_s];
        end
    end

    // Registered unit drive and response valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_op_r     <= OP_NOP;
            md_a_r      <= 32'd0;
            md_b_r      <= 32'd0;
            rsp_valid_r <= 2'b00;
        end else begin
            md_op_r     <= md_op_nx_s;
            md_a_r      <= md_a_nx_s;
            md_b_r      <= md_b_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_hi    = rsp_hi_r;
    assign bus.rsp_lo    = rsp_lo_r;
    assign bus.md_op     = md_op_r;
    assign bus.md_a      = md_a_r;
    assign bus.md_b      = md_b_r;
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter. It contains a cycle model of the multiply/divide
// unit and an architectural reference: per-port HI/LO, the loaded context
// and the round-robin pointer.
module tb_muldiv_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_arbiter_if bus();
    muldiv_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // ---------------- multiply/divide unit model ----------------
    logic [31:0] u_hi, u_lo, u_q, u_r;
    logic [63:0] u_prod;
    logic        u_acc, u_sub, u_dpend;
    int          u_cnt;
    int          div_delay = 0;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic signed [63:0] sa, sb;
        if (uns) return {32'd0, a} * {32'd0, b};
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        return 64'(sa * sb);
    endfunction

    // Returns {remainder, quotient}.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic signed [31:0] sa, sb;
        if (uns) return {a % b, a / b};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // The unit: HI/LO writes on the edge after the op; MADD/MSUB accumulate
    // one cycle later; DIV stays busy for div_delay cycles and then writes.
    always @(posedge clk) begin
        if (rst) begin
            u_hi <= 32'd0; u_lo <= 32'd0; u_acc <= 1'b0; u_sub <= 1'b0;
            u_dpend <= 1'b0; u_cnt <= 0; u_prod <= 64'd0; u_q <= 32'd0; u_r <= 32'd0;
        end else begin
            if (u_acc) begin
                {u_hi, u_lo} <= u_sub ? ({u_hi, u_lo} - u_prod) : ({u_hi, u_lo} + u_prod);
                u_acc <= 1'b0;
            end
            if (u_dpend) begin
                if (u_cnt > 0) u_cnt <= u_cnt - 1;
                else begin u_hi <= u_r; u_lo <= u_q; u_dpend <= 1'b0; end
            end
            case (bus.md_op[3:1])
                3'b010: u_lo <= bus.md_a;
                3'b011: u_hi <= bus.md_a;
                3'b100: {u_hi, u_lo} <= mul64(bus.md_a, bus.md_b, bus.md_op[0]);
                3'b101: begin
                    {u_r, u_q} <= div64(bus.md_a, bus.md_b, bus.md_op[0]);
                    u_dpend <= 1'b1;
                    u_cnt <= div_delay;
                end
                3'b110, 3'b111: begin
                    u_prod <= mul64(bus.md_a, bus.md_b, bus.md_op[0]);
                    u_acc <= 1'b1;
                    u_sub <= bus.md_op[1];
                end
                default: ;
            endcase
        end
    end
    assign bus.md_hi   = u_hi;
    assign bus.md_lo   = u_lo;
    assign bus.md_busy = u_dpend && (u_cnt != 0);

    // ---------------- reference model ----------------
    logic [63:0] ref_sh [2];
    int          ref_ctx;
    int          ref_last;
    logic [3:0]  op_d [2];
    logic [31:0] a_d [2];
    logic [31:0] b_d [2];
    logic [31:0] last_hi, last_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_sh[0] = 64'd0; ref_sh[1] = 64'd0;
        ref_ctx = 0; ref_last = 1;
    endtask

    task automatic drive(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        op_d[p] = op; a_d[p] = a; b_d[p] = b;
        if (p == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
        else begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
        bus.req_valid[p] = 1'b1;
    endtask

    task automatic drive_rand(input int p);
        logic [3:0]  op;
        logic [31:0] a, b;
        op = 4'($urandom_range(0, 15));
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
        if (op[3:1] == 3'b101) begin
            if (b == 32'd0) b = 32'd1;
            if (!op[0] && b == 32'hFFFF_FFFF) b = 32'd3;
        end
        drive(p, op, a, b);
    endtask

    // Serves the request the arbiter should pick now (called mid-cycle while idle),
    // holds rsp_ready low for 'hold' cycles, then completes the handshake.
    task automatic serve(input int k, input int hold, output int served);
        int p, exp_lat, lat, issue_c;
        logic [3:0]  op, exp_md;
        logic [31:0] a, b;
        logic [2:0]  cls;
        logic [1:0]  onehot;
        logic [63:0] pre, exp_r;
        logic        rest;
        if (bus.req_valid == 2'b11) p = (ref_last == 1) ? 0 : 1;
        else p = bus.req_valid[1] ? 1 : 0;
        served = p;
        op = op_d[p]; a = a_d[p]; b = b_d[p]; cls = op[3:1];
        onehot = (p == 1) ? 2'b10 : 2'b01;
        pre = ref_sh[p];
        rest = (p != ref_ctx) && (cls == 3'b010 || cls == 3'b011 || cls == 3'b110 || cls == 3'b111);
        case (cls)
            3'b010:  begin exp_r = {pre[63:32], a};           exp_lat = 3; end
            3'b011:  begin exp_r = {a, pre[31:0]};            exp_lat = 3; end
            3'b100:  begin exp_r = mul64(a, b, op[0]);        exp_lat = 3; end
            3'b101:  begin exp_r = div64(a, b, op[0]);        exp_lat = 4 + k; end
            3'b110:  begin exp_r = pre + mul64(a, b, op[0]);  exp_lat = 4; end
            3'b111:  begin exp_r = pre - mul64(a, b, op[0]);  exp_lat = 4; end
            default: begin exp_r = pre;                       exp_lat = 1; end
        endcase
        if (rest) exp_lat = exp_lat + 2;
        issue_c = rest ? 3 : 1;
        div_delay = k;
        #1;
        chk("req_ready_accept", 64'(bus.req_ready), 64'(onehot));
        @(posedge clk);
        ref_last = p;
        if (cls >= 3'b010) begin ref_ctx = p; ref_sh[p] = exp_r; end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (cls < 3'b010) exp_md = 4'b0000;
            else if (lat == issue_c) exp_md = op;
            else if (rest && lat == 1) exp_md = 4'b0100;
            else if (rest && lat == 2) exp_md = 4'b0110;
            else exp_md = 4'b0000;
            chk("md_op_seq", 64'(bus.md_op), 64'(exp_md));
            chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
            if (cls >= 3'b010 && lat >= issue_c) begin
                chk("md_a_op", 64'(bus.md_a), 64'(a));
                chk("md_b_op", 64'(bus.md_b), 64'(b));
            end
            if (rest && lat == 1) chk("restore_lo", 64'(bus.md_a), 64'(pre[31:0]));
            if (rest && lat == 2) chk("restore_hi", 64'(bus.md_a), 64'(pre[63:32]));
            if (lat == 1) bus.req_valid[p] = 1'b0;
        end while (bus.rsp_valid == 2'b00 && lat < 80);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(onehot));
        chk("rsp_hi", 64'(bus.rsp_hi), 64'(exp_r[63:32]));
        chk("rsp_lo", 64'(bus.rsp_lo), 64'(exp_r[31:0]));
        last_hi = bus.rsp_hi;
        last_lo = bus.rsp_lo;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.rsp_valid), 64'(onehot));
            chk("hold_data", {bus.rsp_hi, bus.rsp_lo}, exp_r);
            chk("hold_no_accept", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready[p] = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        chk("rsp_after_hs", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, mode;
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
        bus.req_op0 = 4'd0; bus.req_op1 = 4'd0;
        bus.req_a0 = 32'd0; bus.req_a1 = 32'd0; bus.req_b0 = 32'd0; bus.req_b1 = 32'd0;
        do_reset();

        // Reset state
        chk("rst_md_op", 64'(bus.md_op), 64'd0);
        chk("rst_md_a", 64'(bus.md_a), 64'd0);
        chk("rst_md_b", 64'(bus.md_b), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

        // Signed MULT -3 * 5 on port 0
        drive(0, 4'b1000, 32'hFFFF_FFFD, 32'd5);
        serve(0, 0, s0);
        chk("mult_hi", 64'(last_hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", 64'(last_lo), 64'h0000_0000_FFFF_FFF1);

        // Context switch with restore
        do_reset();
        drive(0, 4'b0100, 32'd7, 32'd0);
        serve(0, 0, s0);
        chk("mtlo_lo", 64'(last_lo), 64'd7);
        drive(1, 4'b1001, 32'd2, 32'd3);
        serve(0, 0, s0);
        chk("multu_p1_hi", 64'(last_hi), 64'd0);
        chk("multu_p1_lo", 64'(last_lo), 64'd6);
        drive(0, 4'b1101, 32'd1, 32'd1);
        serve(0, 0, s0);
        chk("maddu_hi", 64'(last_hi), 64'd0);
        chk("maddu_lo", 64'(last_lo), 64'd8);

        // Both ports at once, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(0, 4'b1001, 32'(10 + r), 32'd4);
            drive(1, 4'b1001, 32'd9, 32'(7 + r));
            serve(0, 0, s0);
            serve(0, 0, s1);
            if (r == 0) begin
                chk("pair_first", 64'(s0), 64'd0);
                chk("pair_second", 64'(s1), 64'd1);
            end
        end

        // Signed DIV -7 / 2 on port 1
        drive(1, 4'b1010, 32'hFFFF_FFF9, 32'd2);
        serve(3, 0, s0);
        chk("div_lo", 64'(last_lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", 64'(last_hi), 64'h0000_0000_FFFF_FFFF);

        // Response stalled 5 cycles while the other port waits
        drive(0, 4'b1000, 32'h1234_5678, 32'h0000_0100);
        drive(1, 4'b0000, 32'd0, 32'd0);
        serve(0, 5, s0);
        serve(0, 0, s1);
        chk("stall_order", 64'({s0[0], s1[0]}), 64'(2'b01));

        // Reset during a divide wait
        drive(1, 4'b1011, 32'd1000, 32'd7);
        div_delay = 8;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_sh[0] = 64'd0; ref_sh[1] = 64'd0; ref_ctx = 0; ref_last = 1;
        for (int i = 0; i < 16; i++) begin
            chk("no_rsp_after_rst", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
        end
        drive(0, 4'b0001, 32'd0, 32'd0);
        serve(0, 0, s0);
        chk("read0_after_rst", {last_hi, last_lo}, 64'd0);
        drive(1, 4'b0010 & 4'b0011, 32'd0, 32'd0);
        serve(0, 0, s0);
        chk("read1_after_rst", {last_hi, last_lo}, 64'd0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0 || mode == 2) drive_rand(0);
            if (mode == 1 || mode == 2) drive_rand(1);
            serve($urandom_range(0, 3), $urandom_range(0, 2), s0);
            if (bus.req_valid != 2'b00) serve($urandom_range(0, 3), $urandom_range(0, 1), s1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
